pal_cfg_loader: RTL and testbench
=================================

PAL_CFG_LOADER -- requirements
Module: pal_cfg_loader

Interface
REQ-001 SHALL have parameter CFG_BITS, default 288, meaning the total PAL configuration length in bits (AND plane 2*N*P plus OR plane P*M for N=8, P=12, M=8); it must be a multiple of 8.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port RES_N, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port BYTE_IN, input, 8 bits: configuration byte.
REQ-005 SHALL have port BYTE_VALID, input, 1 bit: BYTE_IN is valid.
REQ-006 SHALL have port BYTE_READY, output, 1 bit: the loader accepts a byte this cycle.
REQ-007 SHALL have port CFG_OUT, output, 1 bit: serial configuration bit to the PAL CFG input.
REQ-008 SHALL have port CFG_SHIFT, output, 1 bit: CFG_OUT is valid this cycle and the PAL shifts it in.
REQ-009 SHALL have port CFG_APPLY, output, 1 bit: one-cycle pulse driving the PAL EN input once the load is complete.
REQ-010 SHALL have port BUSY, output, 1 bit: a load is in progress.
REQ-011 SHALL have port ERR, output, 1 bit: sticky error flag.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT, CHECK, APPLY and ERROR.
REQ-013 SHALL assert BYTE_READY only in IDLE, in LOAD, and in CHECK (checksum byte); a transfer occurs when BYTE_VALID=1 and BYTE_READY=1 in the same cycle.
REQ-014 SHALL, on a transfer in IDLE or LOAD, capture the byte into an 8-bit shift register, increment the byte counter, and go to SHIFT on the next cycle.
REQ-015 SHALL, in SHIFT, emit exactly 8 consecutive cycles with CFG_SHIFT=1, bits LSB first; CFG_OUT is registered, so the first bit appears the cycle after the transfer.
REQ-016 SHALL, after 8 shift cycles, return to LOAD if fewer than CFG_BITS/8 bytes have been received, and otherwise go to CHECK (macro defined) or APPLY (macro undefined).
REQ-017 SHALL hold BYTE_READY=0 throughout SHIFT; back-to-back throughput is therefore one byte per 9 cycles.
REQ-018 SHALL accumulate a running XOR of all data bytes; the checksum byte itself is never shifted out.
REQ-019 SHALL, in APPLY, assert CFG_APPLY for exactly one cycle, clear the counters and XOR, then return to IDLE.
REQ-020 SHALL drive BUSY=1 in every state except IDLE and ERROR.
REQ-021 SHALL hold CFG_OUT=0 whenever CFG_SHIFT=0.
REQ-022 SHALL, when BYTE_VALID is held high continuously, accept the next byte in the first cycle after SHIFT ends and never drop a byte.
REQ-023 SHALL size the byte counter as ceil(log2(CFG_BITS/8+1)) bits with no wrap-around; the final-byte compare uses the exact value.

Reset
REQ-024 SHALL, while RES_N=0 at a clock edge, enter IDLE and clear the shift register, counters, XOR and ERR.
REQ-025 SHALL drive outputs to BYTE_READY=0, CFG_OUT=0, CFG_SHIFT=0, CFG_APPLY=0, BUSY=0 and ERR=0 while in reset and in the first cycle after reset.
REQ-026 SHALL, on a reset asserted mid-load, discard the partial load without producing CFG_APPLY; the PAL keeps its previous configuration.

Configuration
REQ-027 SHALL, when macro PAL_CFG_CHECKSUM_EN is defined, require one extra byte in CHECK after the data; if it equals the XOR, go to APPLY, otherwise set ERR, go to ERROR and produce no CFG_APPLY.
REQ-028 SHALL, when PAL_CFG_CHECKSUM_EN is undefined, remove the CHECK state and XOR logic, never set ERR, and go directly from the last SHIFT to APPLY.
REQ-029 SHALL leave ERROR only by reset, with BYTE_READY=0 while in ERROR.

Structure
REQ-030 SHALL place the FSM state enum and the PAL sizing constants (N=8, P=12, M=8, derived CFG_BITS=288) in shared package pal_pkg, also used by the PAL top wrapper.
REQ-031 SHALL implement the byte-to-bit serializer (8-bit shift register plus 3-bit bit counter) as sub-module pal_cfg_serializer; the FSM, counters and checksum stay in pal_cfg_loader.

Verification
REQ-032 SHALL cover a full load with CFG_BITS=16 and macro undefined: bytes 0xA5, 0x3C with VALID held high -> CFG_OUT sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 under CFG_SHIFT, then one CFG_APPLY pulse.
REQ-033 SHALL cover a good checksum with the macro defined: 0xA5, 0x3C, 0x99 -> CFG_APPLY=1 for one cycle and ERR=0.
REQ-034 SHALL cover a bad checksum with the macro defined: 0xA5, 0x3C, 0x00 -> ERR=1, no CFG_APPLY, BYTE_READY=0 until RES_N=0.
REQ-035 SHALL cover reset mid-load: RES_N=0 at the 4th shift of byte 1 -> all outputs 0 next cycle, and a subsequent clean load succeeds.
REQ-036 SHALL cover backpressure: BYTE_VALID toggling 1/0 each cycle -> exactly 2 transfers, 16 CFG_SHIFT cycles, and bit order intact.
REQ-037 SHALL cover default CFG_BITS=288: 36 bytes of 0xFF -> 288 CFG_SHIFT cycles all with CFG_OUT=1, then CFG_APPLY exactly once.

Source files
------------

// File: rtl/pal_pkg.sv
// Shared PAL sizing constants and loader FSM state encoding.
// Used by pal_cfg_loader (optional checksum via PAL_CFG_CHECKSUM_EN) and the PAL top wrapper.
package pal_pkg;

  localparam int PAL_N = 8;
  localparam int PAL_P = 12;
  localparam int PAL_M = 8;
  // AND plane (true and complement of every input per term) plus OR plane
  localparam int PAL_CFG_BITS = 2 * PAL_N * PAL_P + PAL_P * PAL_M;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CHECK,
    ST_APPLY,
    ST_ERROR
  } pal_cfg_state_e;

endpackage

// File: rtl/pal_cfg_serializer.sv
// Byte-to-bit serializer for the PAL configuration chain, LSB first.
// Part of pal_cfg_loader (checksum option PAL_CFG_CHECKSUM_EN lives in the loader).
module pal_cfg_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       shift_en,
  output logic       bit_out,
  output logic       last_bit
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = byte_in;
      cnt_d = 3'd0;
    end else if (shift_en) begin
      sr_d  = {1'b0, sr_q[7:1]};
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= 8'h00;
      cnt_q <= 3'd0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_out  = sr_q[0];
  assign last_bit = (cnt_q == 3'd7);

endmodule

// File: rtl/pal_cfg_loader.sv
// Byte-wide PAL configuration loader: serialises CFG_BITS bits then pulses CFG_APPLY.
// Define PAL_CFG_CHECKSUM_EN to require a trailing XOR checksum byte before applying.
module pal_cfg_loader
  import pal_pkg::*;
#(
  parameter int CFG_BITS = PAL_CFG_BITS
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  output logic       BYTE_READY,
  output logic       CFG_OUT,
  output logic       CFG_SHIFT,
  output logic       CFG_APPLY,
  output logic       BUSY,
  output logic       ERR
);

  localparam int NUM_BYTES = CFG_BITS / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES);

  pal_cfg_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_en_q;
  logic             ready, xfer, load, shifting, apply, busy;
  logic             bit_out, last_bit;
`ifdef PAL_CFG_CHECKSUM_EN
  logic [7:0]       xor_q, xor_d;
  logic             err_q, err_d;
`endif

  pal_cfg_serializer u_ser (
    .clk      (CLK),
    .rst_n    (RES_N),
    .load     (load),
    .byte_in  (BYTE_IN),
    .shift_en (shifting),
    .bit_out  (bit_out),
    .last_bit (last_bit)
  );

  // out_en_q keeps BYTE_READY low for the first cycle after reset
  assign ready = out_en_q && (state_q == ST_IDLE || state_q == ST_LOAD || state_q == ST_CHECK);
  assign xfer  = ready && BYTE_VALID;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shifting = 1'b0;
    apply    = 1'b0;
    busy     = 1'b1;
`ifdef PAL_CFG_CHECKSUM_EN
    xor_d    = xor_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        busy = (state_q == ST_LOAD);
        if (xfer) begin
          load    = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_SHIFT;
`ifdef PAL_CFG_CHECKSUM_EN
          xor_d   = xor_q ^ BYTE_IN;
`endif
        end
      end
      ST_SHIFT: begin
        shifting = 1'b1;
        if (last_bit) begin
          if (cnt_q != LAST_CNT) begin
            state_d = ST_LOAD;
          end else begin
`ifdef PAL_CFG_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_APPLY;
`endif
          end
        end
      end
`ifdef PAL_CFG_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          if (BYTE_IN == xor_q) begin
            state_d = ST_APPLY;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
`endif
      ST_APPLY: begin
        apply   = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
`ifdef PAL_CFG_CHECKSUM_EN
        xor_d   = 8'h00;
`endif
      end
      ST_ERROR: begin
        busy = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RES_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      out_en_q <= 1'b0;
`ifdef PAL_CFG_CHECKSUM_EN
      xor_q    <= 8'h00;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_en_q <= 1'b1;
`ifdef PAL_CFG_CHECKSUM_EN
      xor_q    <= xor_d;
      err_q    <= err_d;
`endif
    end
  end

  assign BYTE_READY = RES_N && ready;
  assign CFG_SHIFT  = RES_N && shifting;
  assign CFG_OUT    = RES_N && shifting && bit_out;
  assign CFG_APPLY  = RES_N && apply;
  assign BUSY       = RES_N && busy;
`ifdef PAL_CFG_CHECKSUM_EN
  assign ERR        = RES_N && err_q;
`else
  assign ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Scoreboard bench for pal_cfg_loader: a 16-bit instance for directed loads and a default 288-bit instance.
// Follows PAL_CFG_CHECKSUM_EN to decide whether a checksum byte is appended.
module tb_pal_cfg_loader;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       sel;

  logic valid0, ready0, out0, shift0, apply0, busy0, err0;
  logic valid1, ready1, out1, shift1, apply1, busy1, err1;
  logic rdySel, busySel;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleNo     = 0;
  int applyCnt0   = 0;
  int applyCnt1   = 0;
  int shiftCnt0   = 0;
  int shiftCnt1   = 0;
  int xferCnt     = 0;
  int xferCycles[$];
  logic expQ0[$];
  logic expQ1[$];
  logic [7:0] txBytes[$];

  // A5 then 3C, LSB first, written out by hand
  logic [15:0] seqA53C = 16'b1010_0101_0011_1100;

  assign valid0  = byte_valid && !sel;
  assign valid1  = byte_valid && sel;
  assign rdySel  = sel ? ready1 : ready0;
  assign busySel = sel ? busy1 : busy0;

  pal_cfg_loader #(.CFG_BITS(16)) dut16 (
    .CLK(clk), .RES_N(res_n), .BYTE_IN(byte_in), .BYTE_VALID(valid0),
    .BYTE_READY(ready0), .CFG_OUT(out0), .CFG_SHIFT(shift0),
    .CFG_APPLY(apply0), .BUSY(busy0), .ERR(err0)
  );

  pal_cfg_loader dut288 (
    .CLK(clk), .RES_N(res_n), .BYTE_IN(byte_in), .BYTE_VALID(valid1),
    .BYTE_READY(ready1), .CFG_OUT(out1), .CFG_SHIFT(shift1),
    .CFG_APPLY(apply1), .BUSY(busy1), .ERR(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s", name);
  endtask

  // Monitor: pops the expected bit every time a DUT shifts, counts pulses and transfers
  always @(negedge clk) begin
    if (shift0) begin
      shiftCnt0++;
      if (expQ0.size() == 0) reportFail("dut16 unexpected CFG_SHIFT");
      else checkOutput("dut16 CFG_OUT bit", int'(out0), int'(expQ0.pop_front()));
    end else begin
      checkOutput("dut16 CFG_OUT idle low", int'(out0), 0);
    end
    if (shift1) begin
      shiftCnt1++;
      if (expQ1.size() == 0) reportFail("dut288 unexpected CFG_SHIFT");
      else checkOutput("dut288 CFG_OUT bit", int'(out1), int'(expQ1.pop_front()));
    end
    if (apply0) applyCnt0++;
    if (apply1) applyCnt1++;
    if (byte_valid && rdySel) begin
      xferCnt++;
      xferCycles.push_back(cycleNo);
    end
  end

  task automatic clearCounts();
    applyCnt0 = 0; applyCnt1 = 0;
    shiftCnt0 = 0; shiftCnt1 = 0;
    xferCnt   = 0;
    xferCycles.delete();
  endtask

  task automatic applyStimulus(input bit toggle, input int budget);
    int idx = 0;
    int cyc = 0;
    bit v   = 1'b1;
    while (idx < txBytes.size() && cyc < budget) begin
      byte_in    = txBytes[idx];
      byte_valid = toggle ? v : 1'b1;
      @(negedge clk);
      if (byte_valid && rdySel) idx++;
      @(posedge clk); #1;
      v = !v;
      cyc++;
    end
    byte_valid = 1'b0;
    if (idx != txBytes.size())
      $display("[TB] FAIL stimulus timeout: accepted %0d of %0d bytes", idx, txBytes.size());
    if (idx != txBytes.size()) begin
      testsRun++;
      testsFailed++;
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busySel && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busySel) reportFail("wait for BUSY low timed out");
    @(posedge clk); #1;
  endtask

  task automatic checkAllLow(input string tag);
    checkOutput({tag, " BYTE_READY"}, int'(ready0), 0);
    checkOutput({tag, " CFG_OUT"},    int'(out0),   0);
    checkOutput({tag, " CFG_SHIFT"},  int'(shift0), 0);
    checkOutput({tag, " CFG_APPLY"},  int'(apply0), 0);
    checkOutput({tag, " BUSY"},       int'(busy0),  0);
    checkOutput({tag, " ERR"},        int'(err0),   0);
  endtask

  task automatic doReset();
    res_n      = 1'b0;
    byte_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkAllLow("in reset");
    checkOutput("dut288 in reset BUSY", int'(busy1), 0);
    res_n = 1'b1;
    @(negedge clk);
    checkAllLow("first cycle after reset");
    @(posedge clk); #1;
    checkOutput("IDLE BYTE_READY", int'(ready0), 1);
    clearCounts();
  endtask

  task automatic loadA53C(input bit toggle, input logic [7:0] cks);
    for (int i = 15; i >= 0; i--) expQ0.push_back(seqA53C[i]);
    txBytes = '{8'hA5, 8'h3C};
`ifdef PAL_CFG_CHECKSUM_EN
    txBytes.push_back(cks);
`endif
    applyStimulus(toggle, 200);
    waitIdle(60);
  endtask

  initial begin
    res_n      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    sel        = 1'b0;
    doReset();

    // Full 16-bit load with VALID held high (good checksum when enabled)
    loadA53C(1'b0, 8'h99);
    checkOutput("full load CFG_APPLY pulses", applyCnt0, 1);
    checkOutput("full load shift cycles", shiftCnt0, 16);
    checkOutput("full load bits left", expQ0.size(), 0);
    checkOutput("full load ERR", int'(err0), 0);
    if (xferCycles.size() >= 2)
      checkOutput("back-to-back transfer spacing", xferCycles[1] - xferCycles[0], 9);
    else
      reportFail("back-to-back transfer spacing: too few transfers");
    clearCounts();

`ifdef PAL_CFG_CHECKSUM_EN
    // Bad checksum: sticky ERR, no apply, no further bytes accepted
    loadA53C(1'b0, 8'h00);
    checkOutput("bad checksum ERR", int'(err0), 1);
    checkOutput("bad checksum CFG_APPLY pulses", applyCnt0, 0);
    byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("ERROR BYTE_READY", int'(ready0), 0);
      checkOutput("ERROR ERR held", int'(err0), 1);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    doReset();
`endif

    // Reset during the 4th shift of byte 1
    expQ0.push_back(1'b1); expQ0.push_back(1'b0); expQ0.push_back(1'b1);
    txBytes = '{8'hA5};
    applyStimulus(1'b0, 20);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    res_n = 1'b0;
    @(posedge clk); #1;
    checkAllLow("after mid-load reset");
    res_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid-load reset CFG_APPLY pulses", applyCnt0, 0);
    checkOutput("mid-load reset bits left", expQ0.size(), 0);
    clearCounts();
    loadA53C(1'b0, 8'h99);
    checkOutput("clean load after reset CFG_APPLY", applyCnt0, 1);
    checkOutput("clean load after reset bits left", expQ0.size(), 0);
    clearCounts();

    // Backpressure: VALID toggles every cycle
    loadA53C(1'b1, 8'h99);
`ifdef PAL_CFG_CHECKSUM_EN
    checkOutput("backpressure transfers", xferCnt, 3);
`else
    checkOutput("backpressure transfers", xferCnt, 2);
`endif
    checkOutput("backpressure shift cycles", shiftCnt0, 16);
    checkOutput("backpressure bits left", expQ0.size(), 0);
    checkOutput("backpressure CFG_APPLY pulses", applyCnt0, 1);
    clearCounts();

    // Default size: 36 bytes of 0xFF on the 288-bit instance
    sel = 1'b1;
    txBytes.delete();
    for (int i = 0; i < 36; i++) txBytes.push_back(8'hFF);
    for (int i = 0; i < 288; i++) expQ1.push_back(1'b1);
`ifdef PAL_CFG_CHECKSUM_EN
    txBytes.push_back(8'h00);
`endif
    applyStimulus(1'b0, 600);
    waitIdle(60);
    checkOutput("288 shift cycles", shiftCnt1, 288);
    checkOutput("288 bits left", expQ1.size(), 0);
    checkOutput("288 CFG_APPLY pulses", applyCnt1, 1);
    checkOutput("288 ERR", int'(err1), 0);
    checkOutput("16-bit instance untouched", applyCnt0, 0);
    sel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
